// File: rtl/dhcp_pkg.sv
// Shared state encoding, parameter defaults and lease helpers for the DHCP lease controller.
package dhcp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_BOUND,
    ST_FALLBACK
  } dhcp_state_t;

  localparam int DEF_CLK_HZ      = 12500000;
  localparam int DEF_RETRY_S     = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_MIN_RENEW_S = 30;
  localparam int DEF_FALLBACK_S  = 60;

  // Renew at half the lease, but never sooner than the configured floor.
  function automatic logic [31:0] renew_count(input logic [31:0] lease,
                                              input logic [31:0] min_renew);
    logic [31:0] half;
    half = {1'b0, lease[31:1]};
    return (half < min_renew) ? min_renew : half;
  endfunction

  function automatic logic lease_infinite(input logic [31:0] lease);
    return (lease == 32'h0000_0000) || (lease == 32'hFFFF_FFFF);
  endfunction

endpackage

// File: rtl/second_tick.sv
// Free-running one-second prescaler; emits a single-cycle tick every CLK_HZ cycles.
module second_tick #(
  parameter int CLK_HZ = 12500000
) (
  input  logic tx_clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge tx_clock) begin
    if (reset || clear) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign tick = !clear && (count_reg == LAST);

endmodule

// File: rtl/dhcp_lease_ctrl.sv
// DHCP lease controller: drives acquisition retries, lease renewal and static-IP fallback.
module dhcp_lease_ctrl
  import dhcp_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int RETRY_S     = DEF_RETRY_S,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int MIN_RENEW_S = DEF_MIN_RENEW_S,
  parameter int FALLBACK_S  = DEF_FALLBACK_S
) (
  input  logic        tx_clock,
  input  logic        reset,
  input  logic        start,
  input  logic        dhcp_success,
  input  logic        dhcp_failed,
  input  logic [31:0] lease,
  output logic        dhcp_enable,
  output logic [3:0]  dhcp_seconds_timer,
  output logic        use_static_ip,
  output logic        bound,
  output logic [2:0]  tries
);

  localparam logic [6:0]  RETRY_LAST    = 7'(RETRY_S - 1);
  localparam logic [6:0]  FALLBACK_LAST = 7'(FALLBACK_S - 1);
  localparam logic [2:0]  MAX_TRIES_W   = 3'(MAX_TRIES);
  localparam logic [31:0] MIN_RENEW_W   = 32'(MIN_RENEW_S);

  dhcp_state_t state_reg, state_next;
  logic [2:0]  tries_reg, tries_next;
  logic [3:0]  timer_reg, timer_next;
  logic [6:0]  wait_cnt_reg, wait_cnt_next;
  logic [6:0]  fb_cnt_reg, fb_cnt_next;
  logic [31:0] renew_cnt_reg, renew_cnt_next;
  logic        infinite_reg, infinite_next;
  logic        bound_reg, bound_next;
  logic        static_reg, static_next;
  logic        sec_tick;

  // Holding the prescaler clear in IDLE aligns second boundaries to the first SEND.
  second_tick #(.CLK_HZ(CLK_HZ)) u_second_tick (
    .tx_clock (tx_clock),
    .reset    (reset),
    .clear    (state_reg == ST_IDLE),
    .tick     (sec_tick)
  );

  always_comb begin
    state_next     = state_reg;
    tries_next     = tries_reg;
    timer_next     = timer_reg;
    wait_cnt_next  = wait_cnt_reg;
    fb_cnt_next    = fb_cnt_reg;
    renew_cnt_next = renew_cnt_reg;
    infinite_next  = infinite_reg;
    bound_next     = bound_reg;
    static_next    = static_reg;

    if (sec_tick && timer_reg != 4'hF &&
        (state_reg == ST_SEND || state_reg == ST_WAIT || state_reg == ST_FALLBACK)) begin
      timer_next = timer_reg + 4'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SEND;
          tries_next = '0;
          timer_next = '0;
        end
      end
      ST_SEND: begin
        state_next    = ST_WAIT;
        tries_next    = (tries_reg == 3'd7) ? tries_reg : tries_reg + 3'd1;
        wait_cnt_next = '0;
      end
      ST_WAIT: begin
        if (sec_tick && wait_cnt_reg != 7'h7F) begin
          wait_cnt_next = wait_cnt_reg + 7'd1;
        end
        // Success is checked first so a simultaneous failure report is ignored.
        if (dhcp_success) begin
          state_next     = ST_BOUND;
          renew_cnt_next = renew_count(lease, MIN_RENEW_W);
          infinite_next  = lease_infinite(lease);
          bound_next     = 1'b1;
          static_next    = 1'b0;
        end else if (dhcp_failed || (sec_tick && wait_cnt_reg >= RETRY_LAST)) begin
          if (tries_reg < MAX_TRIES_W) begin
            state_next = ST_SEND;
          end else begin
            state_next  = ST_FALLBACK;
            fb_cnt_next = '0;
            bound_next  = 1'b0;
            static_next = 1'b1;
          end
        end
      end
      ST_BOUND: begin
        if (sec_tick && !infinite_reg) begin
          if (renew_cnt_reg <= 32'd1) begin
            state_next     = ST_SEND;
            renew_cnt_next = '0;
            tries_next     = '0;
            timer_next     = '0;
          end else begin
            renew_cnt_next = renew_cnt_reg - 32'd1;
          end
        end
      end
      ST_FALLBACK: begin
        if (sec_tick) begin
          if (fb_cnt_reg >= FALLBACK_LAST) begin
            state_next = ST_SEND;
            tries_next = '0;
          end else begin
            fb_cnt_next = fb_cnt_reg + 7'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // Link down abandons everything, whatever the current state.
    if (!start) begin
      state_next     = ST_IDLE;
      tries_next     = '0;
      timer_next     = '0;
      wait_cnt_next  = '0;
      fb_cnt_next    = '0;
      renew_cnt_next = '0;
      infinite_next  = 1'b0;
      bound_next     = 1'b0;
      static_next    = 1'b0;
    end
  end

  always_ff @(posedge tx_clock) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      tries_reg     <= '0;
      timer_reg     <= '0;
      wait_cnt_reg  <= '0;
      fb_cnt_reg    <= '0;
      renew_cnt_reg <= '0;
      infinite_reg  <= 1'b0;
      bound_reg     <= 1'b0;
      static_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tries_reg     <= tries_next;
      timer_reg     <= timer_next;
      wait_cnt_reg  <= wait_cnt_next;
      fb_cnt_reg    <= fb_cnt_next;
      renew_cnt_reg <= renew_cnt_next;
      infinite_reg  <= infinite_next;
      bound_reg     <= bound_next;
      static_reg    <= static_next;
    end
  end

  assign dhcp_enable        = (state_reg == ST_SEND);
  assign dhcp_seconds_timer = timer_reg;
  assign use_static_ip      = static_reg;
  assign bound              = bound_reg;
  assign tries              = tries_reg;

endmodule

// File: tb/tb_dhcp_lease_ctrl.sv
// Bench for dhcp_lease_ctrl: absolute-time behavioural model checked every cycle, plus directed scenarios.
module tb_dhcp_lease_ctrl;

  localparam int CLK   = 10;
  localparam int RETRY = 4;
  localparam int MAXT  = 3;
  localparam int MINR  = 30;
  localparam int FBS   = 60;

  localparam int M_IDLE = 0, M_SEND = 1, M_AWAIT = 2, M_HOLD = 3, M_STATIC = 4;

  logic        tx_clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        dhcp_success = 1'b0;
  logic        dhcp_failed = 1'b0;
  logic [31:0] lease = '0;
  logic        dhcp_enable;
  logic [3:0]  dhcp_seconds_timer;
  logic        use_static_ip;
  logic        bound;
  logic [2:0]  tries;

  dhcp_lease_ctrl #(.CLK_HZ(CLK)) dut (
    .tx_clock           (tx_clock),
    .reset              (reset),
    .start              (start),
    .dhcp_success       (dhcp_success),
    .dhcp_failed        (dhcp_failed),
    .lease              (lease),
    .dhcp_enable        (dhcp_enable),
    .dhcp_seconds_timer (dhcp_seconds_timer),
    .use_static_ip      (use_static_ip),
    .bound              (bound),
    .tries              (tries)
  );

  always #5 tx_clock = ~tx_clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode plus absolute cycle deadlines; seconds are measured from the first SEND.
  int     m_mode = M_IDLE;
  longint m_epoch = 0, m_wait_dl = 0, m_renew_dl = 0, m_fb_dl = 0;
  int     m_tries = 0, m_timer = 0;
  bit     m_bound = 0, m_static = 0, m_inf = 0, m_valid = 0;
  longint cyc = 0;

  function automatic longint nta(input longint x);
    longint off;
    off = (x - m_epoch) % CLK;
    return x + (CLK - 1 - off);
  endfunction

  task automatic model_step(input longint c);
    longint rl;
    if (reset) m_valid = 1;
    if (!m_valid) return;
    if (reset || !start) begin
      m_mode = M_IDLE; m_tries = 0; m_timer = 0;
      m_bound = 0; m_static = 0; m_inf = 0;
      return;
    end
    if (m_mode != M_IDLE && ((c - m_epoch) % CLK) == CLK - 1 &&
        (m_mode == M_SEND || m_mode == M_AWAIT || m_mode == M_STATIC) && m_timer < 15)
      m_timer++;
    case (m_mode)
      M_IDLE: begin
        m_mode = M_SEND; m_epoch = c + 1; m_tries = 0; m_timer = 0;
      end
      M_SEND: begin
        if (m_tries < 7) m_tries++;
        m_wait_dl = nta(c + 1) + longint'(RETRY - 1) * CLK;
        m_mode = M_AWAIT;
      end
      M_AWAIT: begin
        if (dhcp_success) begin
          m_mode = M_HOLD; m_bound = 1; m_static = 0;
          m_inf = (lease == 32'h0) || (lease == 32'hFFFF_FFFF);
          rl = longint'(lease) / 2;
          if (rl < MINR) rl = MINR;
          m_renew_dl = nta(c + 1) + (rl - 1) * CLK;
        end else if (dhcp_failed || c == m_wait_dl) begin
          if (m_tries < MAXT) m_mode = M_SEND;
          else begin
            m_mode = M_STATIC; m_bound = 0; m_static = 1;
            m_fb_dl = nta(c + 1) + longint'(FBS - 1) * CLK;
          end
        end
      end
      M_HOLD: begin
        if (!m_inf && c == m_renew_dl) begin
          m_mode = M_SEND; m_tries = 0; m_timer = 0;
        end
      end
      M_STATIC: begin
        if (c == m_fb_dl) begin
          m_mode = M_SEND; m_tries = 0;
        end
      end
      default: m_mode = M_IDLE;
    endcase
  endtask

  // Compare process: outputs checked at the falling edge, then the model advances one cycle.
  always @(negedge tx_clock) begin
    logic [9:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = {m_mode == M_SEND, 4'(m_timer), m_static, m_bound, 3'(m_tries)};
      act_v = {dhcp_enable, dhcp_seconds_timer, use_static_ip, bound, tries};
      n_tests++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL model cyc=%0d: got en=%b tmr=%0d static=%b bound=%b tries=%0d, expected en=%b tmr=%0d static=%b bound=%b tries=%0d",
                 cyc, act_v[9], act_v[8:5], act_v[4], act_v[3], act_v[2:0],
                 exp_v[9], exp_v[8:5], exp_v[4], exp_v[3], exp_v[2:0]);
      end
    end
    model_step(cyc);
    cyc++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tx_clock);
    #1;
  endtask

  task automatic wait_pulse(input int limit, output bit found, output longint at);
    found = 0;
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (dhcp_enable === 1'b1) begin
        found = 1;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset = 1; start = 0; dhcp_success = 0; dhcp_failed = 0; lease = '0;
    step(); step();
    reset = 0;
  endtask

  function automatic logic [9:0] outs();
    return {dhcp_enable, dhcp_seconds_timer, use_static_ip, bound, tries};
  endfunction

  bit     found;
  longint p, q, p2, p3, p4;
  int     r;
  logic [31:0] lease_tab [7];

  initial begin
    lease_tab = '{32'd0, 32'd1, 32'd10, 32'd60, 32'd100, 32'hFFFF_FFFF, 32'd7};

    // Reset state
    repeat (3) step();
    check("reset_outputs", outs(), 10'd0);
    reset = 0;

    // Scenario 1: success on second WAIT cycle, renewal at 50 s
    do_reset();
    start = 1;
    wait_pulse(5, found, p);
    check("s1_first_pulse", found, 1);
    step();
    step();
    dhcp_success = 1; lease = 32'd100;
    step();
    dhcp_success = 0;
    check("s1_bound", bound, 1);
    check("s1_static", use_static_ip, 0);
    wait_pulse(600, found, q);
    check("s1_renew_found", found, 1);
    check("s1_renew_gap", q - p, 500);

    // Scenario 2 and 5: no reply, retries, fallback, timer saturation
    do_reset();
    start = 1;
    wait_pulse(5, found, p);
    wait_pulse(60, found, p2);
    check("s2_gap1", p2 - p, 40);
    wait_pulse(60, found, p3);
    check("s2_gap2", p3 - p2, 40);
    repeat (45) step();
    check("s2_static", use_static_ip, 1);
    check("s2_tries", tries, 3);
    check("s2_bound", bound, 0);
    repeat (75) step();
    check("s5_timer_sat", dhcp_seconds_timer, 15);
    wait_pulse(600, found, p4);
    check("s2_restart_found", found, 1);
    check("s2_restart_gap", p4 - p3, 640);
    check("s2_static_hold", use_static_ip, 1);
    check("s2_tries_clear", tries, 0);

    // Scenario 3: short lease clamped to 30 s, then infinite lease
    do_reset();
    start = 1;
    wait_pulse(5, found, p);
    step();
    dhcp_success = 1; lease = 32'd10;
    step();
    dhcp_success = 0;
    wait_pulse(400, found, q);
    check("s3_renew_found", found, 1);
    check("s3_renew_gap", q - p, 300);
    check("s3_bound_renewing", bound, 1);
    step();
    dhcp_success = 1; lease = 32'hFFFF_FFFF;
    step();
    dhcp_success = 0;
    wait_pulse(10000, found, q);
    check("s3_infinite_no_pulse", found, 0);
    check("s3_infinite_bound", bound, 1);

    // Scenario 4: success and failure together
    do_reset();
    start = 1;
    wait_pulse(5, found, p);
    step();
    dhcp_success = 1; dhcp_failed = 1; lease = 32'd100;
    step();
    dhcp_success = 0; dhcp_failed = 0;
    check("s4_bound", bound, 1);
    check("s4_tries", tries, 1);
    wait_pulse(100, found, q);
    check("s4_no_resend", found, 0);

    // Scenario 6: start dropped mid-WAIT, reset mid-BOUND
    do_reset();
    start = 1;
    wait_pulse(5, found, p);
    step();
    start = 0;
    step();
    check("s6_drop_outputs", outs(), 10'd0);
    wait_pulse(50, found, q);
    check("s6_drop_no_pulse", found, 0);
    start = 1;
    wait_pulse(3, found, p);
    check("s6_restart_pulse", found, 1);
    step();
    dhcp_success = 1; lease = 32'd100;
    step();
    dhcp_success = 0;
    check("s6_bound", bound, 1);
    reset = 1; start = 0;
    step();
    reset = 0;
    check("s6_reset_outputs", outs(), 10'd0);
    wait_pulse(50, found, q);
    check("s6_reset_no_pulse", found, 0);

    // Randomized traffic against the model
    do_reset();
    start = 1;
    for (int i = 0; i < 8000; i++) begin
      step();
      reset = ($urandom_range(0, 999) == 0);
      if (start) start = ($urandom_range(0, 799) != 0);
      else       start = ($urandom_range(0, 19) == 0);
      dhcp_success = ($urandom_range(0, 59) == 0);
      dhcp_failed  = ($urandom_range(0, 39) == 0);
      r = $urandom_range(0, 7);
      lease = (r == 7) ? 32'($urandom_range(0, 200)) : lease_tab[r];
    end
    reset = 0; dhcp_success = 0; dhcp_failed = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dhcp_lease_ctrl.md
DHCP_LEASE_CTRL -- requirements
Module: dhcp_lease_ctrl

Interface
REQ-001 Parameter CLK_HZ, default 12500000, tx_clock frequency in Hz.
REQ-002 Parameter RETRY_S, default 4, seconds to wait for a reply before resending.
REQ-003 Parameter MAX_TRIES, default 3, send attempts before falling back.
REQ-004 Parameter MIN_RENEW_S, default 30, floor on the renewal interval in seconds.
REQ-005 Parameter FALLBACK_S, default 60, seconds spent in FALLBACK before restarting acquisition.
REQ-006 tx_clock  in  1  sole clock; all logic is on its rising edge.
REQ-007 reset  in  1  synchronous, active-high.
REQ-008 start  in  1  level; high = link up, so DHCP acquisition is permitted.
REQ-009 dhcp_success  in  1  ACK received, from the DHCP engine.
REQ-010 dhcp_failed  in  1  NAK or other reply received, from the DHCP engine.
REQ-011 lease  in  32  lease in seconds; valid in the cycle dhcp_success is high.
REQ-012 dhcp_enable  out  1  one-cycle pulse that drives the DHCP engine tx_enable.
REQ-013 dhcp_seconds_timer  out  4  seconds since acquisition began, saturating at 15.
REQ-014 use_static_ip  out  1  high while no lease has been obtained after exhausting retries.
REQ-015 bound  out  1  high while a valid lease is held.
REQ-016 tries  out  3  send attempts made in the current acquisition.

Function
REQ-017 Prescaler: counts 0..CLK_HZ-1 and produces sec_tick, a one-cycle pulse when the count equals CLK_HZ-1; the count wraps to 0 on that cycle.
REQ-018 States are IDLE, SEND, WAIT, BOUND and FALLBACK.
REQ-019 IDLE: on start=1, go to SEND; clear tries, dhcp_seconds_timer and the prescaler.
REQ-020 SEND: dhcp_enable=1 for exactly this cycle; tries increments (saturating at 7); the wait counter clears; next state is WAIT.
REQ-021 WAIT: the wait counter increments on sec_tick.
REQ-022 WAIT, dhcp_success=1: go to BOUND; latch the renewal count; bound=1; use_static_ip=0.
REQ-023 WAIT, dhcp_failed=1, or wait counter reaches RETRY_S: go to SEND if tries < MAX_TRIES, else go to FALLBACK.
REQ-024 If dhcp_success and dhcp_failed are high in the same cycle, success wins.
REQ-025 Renewal count = lease>>1, clamped up to MIN_RENEW_S; a lease of 0 or 32'hFFFFFFFF means infinite (no renewal).
REQ-026 BOUND: the renewal count decrements on sec_tick; when it reaches 0, clear tries and dhcp_seconds_timer and go to SEND; bound stays 1 during the renewal attempt.
REQ-027 Renewal outcomes: success reloads the renewal count; exhausted retries clear bound and go to FALLBACK.
REQ-028 FALLBACK: use_static_ip=1; after FALLBACK_S sec_ticks, clear tries and go to SEND; use_static_ip stays 1 until a success.
REQ-029 dhcp_seconds_timer increments on sec_tick in SEND, WAIT and FALLBACK, saturating at 15; it holds in BOUND.
REQ-030 start=0 in any state: next cycle IDLE, with bound=0, use_static_ip=0 and tries=0.
REQ-031 dhcp_enable never pulses twice without a WAIT state between the pulses.
REQ-032 All counters have explicit widths; the renewal counter is 32 bits, wait and fallback counters are 7 bits, and there is no silent wrap.

Reset
REQ-033 On reset: state=IDLE; all outputs 0; prescaler, wait, fallback and renewal counters 0.
REQ-034 Reset takes priority over every other input in the same cycle, including reset asserted mid-WAIT or mid-BOUND.

Structure
REQ-035 The state encoding and the parameter defaults live in the shared package dhcp_pkg.
REQ-036 The prescaler is a sub-module, second_tick, with ports tx_clock, reset, clear and tick.

Verification
REQ-037 Bench uses CLK_HZ=10 throughout.
REQ-038 Scenario 1: start=1, success with lease=100 on the 2nd cycle of WAIT -> exactly one dhcp_enable pulse; bound=1; next dhcp_enable 500 cycles later (50 s).
REQ-039 Scenario 2: start=1, no reply -> dhcp_enable pulses 40 cycles apart, 3 pulses total; use_static_ip=1; restart 600 cycles after entering FALLBACK.
REQ-040 Scenario 3: success with lease=10 -> renewal after MIN_RENEW_S=30 s (300 cycles); lease=32'hFFFFFFFF -> no further dhcp_enable for 10000 cycles.
REQ-041 Scenario 4: dhcp_success and dhcp_failed asserted together -> BOUND, no resend.
REQ-042 Scenario 5: no reply for 20 s -> dhcp_seconds_timer saturates at 15 (no wrap to 0).
REQ-043 Scenario 6: start dropped mid-WAIT, or reset mid-BOUND -> IDLE next cycle, all outputs 0, no dhcp_enable until start is high again.
